// File: rtl/gabor_cluster_conv_seq.sv
// gabor_cluster_conv_seq
// Sequential clustered-coefficient Gabor convolution. One KSIZE x KSIZE window
// is accepted per handshake; pixels are summed per coefficient cluster using a
// runtime tap-to-group map, then one time-shared signed multiplier folds the
// group sums into a single full-precision result.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   win_pix           window pixels, tap t at [t*PIX_W +: PIX_W], row-major
//   tap_group         group id per tap; id >= NUM_GROUPS drops the tap
//   in_valid/in_ready window handshake
//   coef_we/addr/wdata coefficient write port (accepted only in IDLE)
//   coef_err          one-cycle pulse when a write is rejected
//   result            signed sum of coeff[g]*group_sum[g], COEFF_FRAC frac bits
//   out_valid/out_ready result handshake
//
// state | meaning
// IDLE  | ready for a window; coefficient writes allowed
// ACCUM | one tap per cycle added into its group sum
// MAC   | one group per cycle: acc += coeff[g] * group_sum[g]
// OUT   | result held until downstream accepts it
module gabor_cluster_conv_seq #(
   parameter int KSIZE      = 5,
   parameter int NUM_GROUPS = 5,
   parameter int PIX_W      = 8,
   parameter int COEFF_W    = 16,
   parameter int COEFF_FRAC = 8,
   localparam int T      = KSIZE * KSIZE,
   localparam int GID_W  = $clog2(NUM_GROUPS + 1),
   localparam int ADDR_W = $clog2(NUM_GROUPS),
   localparam int SUM_W  = PIX_W + $clog2(T + 1),
   localparam int ACC_W  = COEFF_W + SUM_W + 1 + $clog2(NUM_GROUPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [T*PIX_W-1:0]       win_pix,
   input  logic [T*GID_W-1:0]       tap_group,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     coef_we,
   input  logic [ADDR_W-1:0]        coef_addr,
   input  logic [COEFF_W-1:0]       coef_wdata,
   output logic                     coef_err,
   output logic [ACC_W-1:0]         result,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int TAP_W  = (T > 1) ? $clog2(T) : 1;
   localparam int PROD_W = COEFF_W + SUM_W + 1;

   // The result inherits the coefficient binary point; no logic depends on it.
   if (COEFF_FRAC > COEFF_W) begin : g_coeff_frac_out_of_range
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_MAC, S_OUT} state_t;

   state_t                    r_state;
   logic [T*PIX_W-1:0]        r_pix;
   logic [T*GID_W-1:0]        r_grp;
   logic [TAP_W-1:0]          r_tap;
   logic [ADDR_W-1:0]         r_gcnt;
   logic [SUM_W-1:0]          r_gsum  [NUM_GROUPS];
   logic [COEFF_W-1:0]        r_coeff [NUM_GROUPS];
   logic [ACC_W-1:0]          r_acc;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic                      r_err;

   logic [PIX_W-1:0]          w_tap_pix;
   logic [GID_W-1:0]          w_tap_gid;
   logic [COEFF_W-1:0]        w_sel_coeff;
   logic [SUM_W-1:0]          w_sel_sum;
   logic signed [PROD_W-1:0]  w_prod;
   logic                      w_coef_ok;

   assign w_tap_pix = r_pix[r_tap*PIX_W +: PIX_W];
   assign w_tap_gid = r_grp[r_tap*GID_W +: GID_W];

   always_comb begin
      w_sel_coeff = '0;
      w_sel_sum   = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (r_gcnt == ADDR_W'(g)) begin
            w_sel_coeff = r_coeff[g];
            w_sel_sum   = r_gsum[g];
         end
      end
   end

   // Group sum is unsigned: a zero MSB makes it a non-negative signed operand.
   assign w_prod = $signed(w_sel_coeff) * $signed({1'b0, w_sel_sum});

   assign w_coef_ok = coef_we && (r_state == S_IDLE) &&
                      (coef_addr < ADDR_W'(NUM_GROUPS));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pix       <= '0;
         r_grp       <= '0;
         r_tap       <= '0;
         r_gcnt      <= '0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         for (int g = 0; g < NUM_GROUPS; g++) begin
            r_gsum[g]  <= '0;
            r_coeff[g] <= '0;
         end
      end else begin
         r_err <= coef_we && !w_coef_ok;
         // Lands on the same edge as an accept, so that window sees the new value.
         if (w_coef_ok) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
               if (coef_addr == ADDR_W'(g)) r_coeff[g] <= coef_wdata;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_pix      <= win_pix;
                  r_grp      <= tap_group;
                  r_tap      <= '0;
                  r_acc      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ACCUM;
                  for (int g = 0; g < NUM_GROUPS; g++) r_gsum[g] <= '0;
               end
            end
            S_ACCUM: begin
               // Masked ids match no group and are dropped.
               for (int g = 0; g < NUM_GROUPS; g++) begin
                  if (w_tap_gid == GID_W'(g))
                     r_gsum[g] <= r_gsum[g] + SUM_W'(w_tap_pix);
               end
               r_tap <= r_tap + 1'b1;
               if (r_tap == TAP_W'(T - 1)) begin
                  r_gcnt  <= '0;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc  <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
               r_gcnt <= r_gcnt + 1'b1;
               if (r_gcnt == ADDR_W'(NUM_GROUPS - 1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_acc;
   assign coef_err  = r_err;

endmodule

// File: tb/tb_gabor_cluster_conv_seq.sv
module tb_gabor_cluster_conv_seq;

   localparam int KSIZE = 5;
   localparam int NG    = 5;
   localparam int PIX_W = 8;
   localparam int CW    = 16;
   localparam int T     = KSIZE * KSIZE;
   localparam int GID_W = 3;
   localparam int AW    = 3;
   localparam int ACC_W = 33;
   localparam int LAT   = T + NG + 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [T*PIX_W-1:0]    win_pix;
   logic [T*GID_W-1:0]    tap_group;
   logic                  in_valid;
   logic                  in_ready;
   logic                  coef_we;
   logic [AW-1:0]         coef_addr;
   logic [CW-1:0]         coef_wdata;
   logic                  coef_err;
   logic [ACC_W-1:0]      result;
   logic                  out_valid;
   logic                  out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc = 0;

   gabor_cluster_conv_seq #(
      .KSIZE(KSIZE), .NUM_GROUPS(NG), .PIX_W(PIX_W), .COEFF_W(CW), .COEFF_FRAC(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .win_pix(win_pix), .tap_group(tap_group),
      .in_valid(in_valid), .in_ready(in_ready), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
      .result(result), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic write_coef(input int a, input int d);
      coef_we    = 1'b1;
      coef_addr  = AW'(a);
      coef_wdata = CW'(d);
      tick();
      coef_we    = 1'b0;
   endtask

   // Groups 0..4 get 8,8,4,4,1 taps.
   task automatic load_map135(input int pix);
      for (int t = 0; t < T; t++) begin
         win_pix[t*PIX_W +: PIX_W] = PIX_W'(pix);
         if (t < 8)       tap_group[t*GID_W +: GID_W] = 3'd0;
         else if (t < 16) tap_group[t*GID_W +: GID_W] = 3'd1;
         else if (t < 20) tap_group[t*GID_W +: GID_W] = 3'd2;
         else if (t < 24) tap_group[t*GID_W +: GID_W] = 3'd3;
         else             tap_group[t*GID_W +: GID_W] = 3'd4;
      end
   endtask

   task automatic accept();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic wait_out(input string tag, input longint exp, input bit chk_lat);
      int n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, longint'(out_valid), 1);
      if (chk_lat) check({tag, "_lat"}, longint'(cyc - acc_cyc + 1), LAT);
      check({tag, "_res"}, longint'($signed(result)), exp);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0;
      coef_wdata = '0; out_ready = 1'b1; win_pix = '0; tap_group = '0;
      tick();
      do_reset();
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_result", longint'(result), 0);
      check("rst_coef_err", longint'(coef_err), 0);

      // 135 deg map, all ones, coeff 256: 25*256
      for (int g = 0; g < NG; g++) write_coef(g, 256);
      load_map135(1);
      accept();
      check("acc_in_ready", longint'(in_ready), 0);
      win_pix = '1;
      tap_group = '0;
      wait_out("map135", 6400, 1'b1);
      handshake();
      check("hs_out_valid", longint'(out_valid), 0);
      check("hs_in_ready", longint'(in_ready), 1);

      // sign/width: 25*255*-32768
      write_coef(0, 16'h8000);
      for (int g = 1; g < NG; g++) write_coef(g, 0);
      for (int t = 0; t < T; t++) begin
         win_pix[t*PIX_W +: PIX_W] = 8'd255;
         tap_group[t*GID_W +: GID_W] = 3'd0;
      end
      accept();
      wait_out("neg", -208896000, 1'b1);
      handshake();

      // Masked taps 0..4, rest group 1, pixels 2, coeff[1]=3: 20*2*3
      write_coef(1, 3);
      for (int t = 0; t < T; t++) begin
         win_pix[t*PIX_W +: PIX_W] = 8'd2;
         tap_group[t*GID_W +: GID_W] = (t < 5) ? 3'd7 : 3'd1;
      end
      out_ready = 1'b0;
      accept();
      wait_out("mask", 120, 1'b1);

      // Backpressure: result held, extra in_valid ignored.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", longint'(out_valid), 1);
         check("bp_result", longint'($signed(result)), 120);
         check("bp_in_ready", longint'(in_ready), 0);
      end
      in_valid = 1'b0;
      handshake();
      check("bp_in_ready_after", longint'(in_ready), 1);
      accept();
      check("bp_next_accept", longint'(in_ready), 0);
      wait_out("bp_next", 120, 1'b1);
      handshake();

      // Rejected write: address out of range in IDLE.
      write_coef(5, 100);
      check("bad_addr_err", longint'(coef_err), 1);
      tick();
      check("bad_addr_err_clr", longint'(coef_err), 0);

      // Write during MAC rejected, old coefficients used.
      for (int g = 0; g < NG; g++) write_coef(g, 256);
      load_map135(1);
      accept();
      repeat (T + 1) tick();
      write_coef(0, 0);
      check("mac_wr_err", longint'(coef_err), 1);
      tick();
      check("mac_wr_err_clr", longint'(coef_err), 0);
      wait_out("mac_wr", 6400, 1'b0);
      handshake();

      // Write coincident with accept: new coeff[0]=512 used: 8*512+17*256
      coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd512;
      accept();
      coef_we = 1'b0;
      check("coinc_err", longint'(coef_err), 0);
      wait_out("coinc", 8448, 1'b1);
      handshake();

      // Reset in cycle 12 of ACCUM aborts the window and clears coefficients.
      accept();
      repeat (11) tick();
      do_reset();
      check("abort_in_ready", longint'(in_ready), 1);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
         end
         check("abort_no_valid", longint'(seen), 0);
      end
      accept();
      wait_out("zero_coef", 0, 1'b1);
      handshake();
      for (int g = 0; g < NG; g++) write_coef(g, 256);
      accept();
      wait_out("reload", 6400, 1'b1);
      handshake();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
